// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable data bits, parity and stop bits.
// Shared oversampled tick drives a TX shifter and a centre-sampling RX.
module uart_core_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [DW-1:0] DIV_M1   = DW'(DIV - 1);
  localparam logic [SW-1:0] SUB_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STP = BW'(STOP_BITS - 1);
  localparam logic          ODD      = (PARITY == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DIV_M1);

  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  logic [2:0]           tx_st_q, tx_st_d;
  logic [SW-1:0]        tx_sub_q, tx_sub_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_end;

  assign tx_end = tick && (tx_sub_q == SUB_END);

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_sub_d  = tx_sub_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    if (tx_st_q != S_IDLE && tick) tx_sub_d = tx_sub_q + 1'b1;
    if (tx_end) tx_sub_d = '0;
    unique case (tx_st_q)
      S_IDLE: if (tx_start) begin
        tx_st_d  = S_START;
        tx_sh_d  = tx_data;
        tx_par_d = (^tx_data) ^ ODD;
        tx_sub_d = '0;
        tx_d     = 1'b0;
      end
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_bit_d = '0;
        tx_d     = tx_sh_q[0];
        tx_sh_d  = tx_sh_q >> 1;
      end
      S_DATA: if (tx_end) begin
        if (tx_bit_q == LAST_BIT) begin
          tx_bit_d = '0;
          tx_st_d  = (PARITY != 0) ? S_PAR : S_STOP;
          tx_d     = (PARITY != 0) ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
        end
      end
      S_PAR: if (tx_end) begin
        tx_st_d  = S_STOP;
        tx_bit_d = '0;
        tx_d     = 1'b1;
      end
      S_STOP: if (tx_end) begin
        if (tx_bit_q == LAST_STP) begin
          tx_st_d   = S_IDLE;
          tx_done_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q   <= S_IDLE;
      tx_sub_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_sub_q  <= tx_sub_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_st_q != S_IDLE);
  assign tx_done = tx_done_q;

  logic                 rx_s1_q, rx_s2_q;
  logic [2:0]           rx_st_q, rx_st_d;
  logic [SW-1:0]        rx_sub_q, rx_sub_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_samp;

  assign rx_samp = tick && (rx_sub_q == SUB_END);

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_sub_d  = rx_sub_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_par_d  = rx_par_q;
    rx_data_d = rx_data_q;
    rx_perr_d = rx_perr_q;
    rx_ferr_d = rx_ferr_q;
    rx_done_d = 1'b0;
    if (rx_st_q != S_IDLE && tick) rx_sub_d = rx_sub_q + 1'b1;
    if (rx_samp) rx_sub_d = '0;
    unique case (rx_st_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_st_d  = S_START;
        rx_sub_d = '0;
      end
      // Half-bit recheck of the start bit rejects short glitches
      S_START: if (tick && rx_sub_q == SUB_HALF) begin
        rx_sub_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_samp) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        else                      rx_bit_d = rx_bit_q + 1'b1;
      end
      S_PAR: if (rx_samp) begin
        rx_par_d = rx_s2_q;
        rx_st_d  = S_STOP;
      end
      S_STOP: if (rx_samp) begin
        rx_st_d   = S_IDLE;
        rx_data_d = rx_sh_q;
        rx_perr_d = (PARITY != 0) && (rx_par_q ^ (^rx_sh_q) ^ ODD);
        rx_ferr_d = !rx_s2_q;
        rx_done_d = 1'b1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_sub_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_data_q <= '0;
      rx_done_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_sub_q  <= rx_sub_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      rx_data_q <= rx_data_d;
      rx_done_q <= rx_done_d;
      rx_perr_q <= rx_perr_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
endmodule
